// File: rtl/fpu_divider_stage2_pkg.sv
// ---------------------------------------------------------------------------
// fpu_divider_stage2_pkg
// Shared types and constants for the FPU stage-2 mantissa divider.
//   fsm_state      : controller states IDLE / DIVIDE / DONE
//   EXPONENT_BIAS  : single-precision exponent bias
//   QUOTIENT_BITS  : number of quotient bits developed (one per DIVIDE cycle)
//   biased_exponent: expA - expB + bias, 10-bit two's complement, wrapping
// ---------------------------------------------------------------------------
package fpu_divider_stage2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } fsm_state;

    localparam logic [9:0] EXPONENT_BIAS = 10'd127;
    localparam int         QUOTIENT_BITS = 26;

    // Two extra bits of headroom let the result go negative (underflow) or
    // exceed 255 (overflow) so stage 3 can detect both cases.
    function automatic logic [9:0] biased_exponent(input logic [7:0] exp_a,
                                                   input logic [7:0] exp_b);
        return {2'b00, exp_a} - {2'b00, exp_b} + EXPONENT_BIAS;
    endfunction

endpackage

// File: rtl/fpu_divider_stage2_if.sv
// ---------------------------------------------------------------------------
// fpu_divider_stage2_if
// Operation/result bundle between stage 1, the stage-2 divider and stage 3.
//   in_valid, in_ready        : input handshake
//   operand_sign/exponent/fraction_a/b : dividend (a) and divisor (b)
//   calculated_exponent/fraction, remainder, result_sign : results
//   result_valid              : one-cycle pulse, results are new
//
// Handshake: an operation transfers on the rising edge where
// in_valid && in_ready are both high. in_ready is registered and depends
// only on divider state; while it is low the producer holds in_valid and
// its operands stable and the divider ignores them. The result side has no
// backpressure: result_valid is a single-cycle pulse that stage 3 always
// captures.
// ---------------------------------------------------------------------------
interface fpu_divider_stage2_if;

    logic        in_valid;
    logic        in_ready;
    logic        operand_sign_a;
    logic        operand_sign_b;
    logic [7:0]  operand_exponent_a;
    logic [7:0]  operand_exponent_b;
    logic [23:0] operand_fraction_a;
    logic [23:0] operand_fraction_b;
    logic [9:0]  calculated_exponent;
    logic [48:0] calculated_fraction;
    logic [26:0] remainder;
    logic        result_sign;
    logic        result_valid;

    // Upstream/downstream side (stage-1 producer, stage-3 consumer).
    modport master (
        output in_valid,
        output operand_sign_a, operand_sign_b,
        output operand_exponent_a, operand_exponent_b,
        output operand_fraction_a, operand_fraction_b,
        input  in_ready,
        input  calculated_exponent, calculated_fraction,
        input  remainder, result_sign, result_valid
    );

    // Divider side.
    modport slave (
        input  in_valid,
        input  operand_sign_a, operand_sign_b,
        input  operand_exponent_a, operand_exponent_b,
        input  operand_fraction_a, operand_fraction_b,
        output in_ready,
        output calculated_exponent, calculated_fraction,
        output remainder, result_sign, result_valid
    );

endinterface

// File: rtl/fpu_divider_step.sv
// ---------------------------------------------------------------------------
// fpu_divider_step
// One combinational radix-2 restoring division step.
//   i_rem       : current partial remainder (26 bits)
//   i_b         : divisor mantissa (1.23)
//   i_shift     : shift the kept remainder left for the next bit
//   o_q_bit     : quotient bit for this step
//   o_rem_next  : remainder for the next cycle (shifted when i_shift)
//   o_rem_final : low 24 bits of the unshifted kept remainder (final R)
// ---------------------------------------------------------------------------
module fpu_divider_step (
    input  logic [25:0] i_rem,
    input  logic [23:0] i_b,
    input  logic        i_shift,
    output logic        o_q_bit,
    output logic [25:0] o_rem_next,
    output logic [23:0] o_rem_final
);

    logic [26:0] w_trial;
    logic [25:0] w_rem_kept;

    // One extra bit on top of the 26-bit difference acts as the borrow:
    // it is set exactly when rem < B, i.e. the trial went negative.
    assign w_trial     = {1'b0, i_rem} - {3'b000, i_b};
    assign o_q_bit     = ~w_trial[26];
    assign w_rem_kept  = o_q_bit ? w_trial[25:0] : i_rem;
    assign o_rem_next  = i_shift ? {w_rem_kept[24:0], 1'b0} : w_rem_kept;
    // After the last step R < B < 2^24, so the low 24 bits hold all of it.
    assign o_rem_final = w_rem_kept[23:0];

endmodule

// File: rtl/fpu_divider_stage2.sv
// ---------------------------------------------------------------------------
// fpu_divider_stage2
// Iterative radix-2 restoring mantissa divider (FPU stage 2). Develops
// Q = floor(A * 2^25 / B) one bit per clock, plus the remainder, the
// biased exponent and the result sign. Throughput: one operation per 28
// cycles; a zero divisor mantissa finishes in a single cycle with Q = R = 0.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   bus       : slave side of fpu_divider_stage2_if (handshake + data)
//   dbg_state : current controller state, for observation only
// ---------------------------------------------------------------------------
module fpu_divider_stage2
    import fpu_divider_stage2_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    fpu_divider_stage2_if.slave         bus,
    output fsm_state                    dbg_state
);

    fsm_state    r_state;
    logic [4:0]  r_count;
    logic [25:0] r_rem;
    logic [25:0] r_q;
    logic [23:0] r_b;
    logic [9:0]  r_exp;
    logic        r_sign;

    logic        r_in_ready;
    logic        r_result_valid;
    logic [9:0]  r_calc_exp;
    logic [48:0] r_calc_frac;
    logic [26:0] r_remainder;
    logic        r_result_sign;

    logic        w_q_bit;
    logic [25:0] w_rem_next;
    logic [23:0] w_rem_final;
    logic [25:0] w_quotient;
    logic [9:0]  w_in_exp;
    logic        w_in_sign;

    fpu_divider_step u_step (
        .i_rem       (r_rem),
        .i_b         (r_b),
        .i_shift     (r_count != 5'd0),
        .o_q_bit     (w_q_bit),
        .o_rem_next  (w_rem_next),
        .o_rem_final (w_rem_final)
    );

    assign w_in_exp  = biased_exponent(bus.operand_exponent_a, bus.operand_exponent_b);
    assign w_in_sign = bus.operand_sign_a ^ bus.operand_sign_b;

    // r_q is cleared at transfer, so bit 0 is still zero on the last step
    // and OR-ing in the live bit completes the quotient.
    assign w_quotient = r_q | {25'd0, w_q_bit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_count        <= 5'd0;
            r_rem          <= '0;
            r_q            <= '0;
            r_b            <= '0;
            r_exp          <= '0;
            r_sign         <= 1'b0;
            r_in_ready     <= 1'b1;
            r_result_valid <= 1'b0;
            r_calc_exp     <= '0;
            r_calc_frac    <= '0;
            r_remainder    <= '0;
            r_result_sign  <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone means transfer.
                    if (bus.in_valid) begin
                        r_b        <= bus.operand_fraction_b;
                        r_rem      <= {2'b00, bus.operand_fraction_a};
                        r_q        <= '0;
                        r_count    <= 5'(QUOTIENT_BITS - 1);
                        r_exp      <= w_in_exp;
                        r_sign     <= w_in_sign;
                        r_in_ready <= 1'b0;
                        if (bus.operand_fraction_b == 24'd0) begin
                            // Zero divisor: downstream special-case logic
                            // overrides the result, so just report zeros.
                            r_state        <= DONE;
                            r_result_valid <= 1'b1;
                            r_calc_exp     <= w_in_exp;
                            r_result_sign  <= w_in_sign;
                            r_calc_frac    <= '0;
                            r_remainder    <= '0;
                        end else begin
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r_q[r_count] <= w_q_bit;
                    r_rem        <= w_rem_next;
                    if (r_count == 5'd0) begin
                        r_state        <= DONE;
                        r_result_valid <= 1'b1;
                        r_calc_exp     <= r_exp;
                        r_result_sign  <= r_sign;
                        r_calc_frac    <= {1'b0, w_quotient, 22'd0};
                        r_remainder    <= {3'b000, w_rem_final};
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready            = r_in_ready;
    assign bus.result_valid        = r_result_valid;
    assign bus.calculated_exponent = r_calc_exp;
    assign bus.calculated_fraction = r_calc_frac;
    assign bus.remainder           = r_remainder;
    assign bus.result_sign         = r_result_sign;
    assign dbg_state               = r_state;

endmodule
